// File: rtl/triumph_if_stage.sv
// Instruction fetch stage: issues word fetches over req/gnt/rvalid and buffers responses in a prefetch FIFO for ID.
// Optional macro TRIUMPH_IF_MISALIGN_CHK_EN adds fetch_misalign_o and halts fetch after a misaligned branch target.
module triumph_if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    input  logic        id_ready_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i
`ifdef TRIUMPH_IF_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o
`endif
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    typedef enum logic {IDLE, REQ} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    cnt_t        out_q, out_d;
    cnt_t        disc_q, disc_d;
    cnt_t        cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        halt_d;
    ptr_t        rd_ptr_q, wr_ptr_q, pq_rd_q, pq_wr_q;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pcf_mem  [FIFO_DEPTH];
    logic [31:0] pq_mem   [FIFO_DEPTH];

    logic [31:0] tgt, pc_eff;
    logic        granted, rsp, drop, push, pop;
    logic        busy, issue, launch;

    assign tgt     = branch_target_i & 32'hFFFF_FFFC;
    assign granted = (state_q == REQ) && instr_gnt_i;
    assign rsp     = instr_rvalid_i && (out_q != '0);
    assign drop    = rsp && (disc_q != '0);
    assign push    = rsp && !drop && !branch_valid_i;
    assign pop     = instr_valid_o && id_ready_i && !branch_valid_i;
    assign pc_eff  = branch_valid_i ? tgt : pc_q;

`ifdef TRIUMPH_IF_MISALIGN_CHK_EN
    logic halt_q, misalign_q;

    assign halt_d = branch_valid_i ? (branch_target_i[1:0] != 2'b00) : halt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halt_q     <= halt_d;
            misalign_q <= branch_valid_i && (branch_target_i[1:0] != 2'b00);
        end
    end

    assign fetch_misalign_o = misalign_q;
`else
    assign halt_d = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        out_d   = out_q + cnt_t'(granted) - cnt_t'(rsp);
        cnt_d   = cnt_q + cnt_t'(push) - cnt_t'(pop);
        disc_d  = disc_q - cnt_t'(drop) + cnt_t'(granted && kill_q);
        kill_d  = kill_q && !granted;
        state_d = IDLE;
        addr_d  = addr_q;
        pc_d    = pc_eff;
        // A redirect flushes the FIFO and turns every fetch still owed by memory into a discard.
        if (branch_valid_i) begin
            cnt_d  = '0;
            disc_d = out_d;
            kill_d = (state_q == REQ) && !instr_gnt_i;
        end
        // Slot check uses next-cycle counts so outstanding plus buffered never exceeds the FIFO.
        busy   = (state_q == REQ) && !instr_gnt_i;
        issue  = fetch_en_i && !halt_d && ((out_d + cnt_d) < DEPTH_C);
        launch = ((state_q == IDLE) || granted) && issue;
        if (busy || launch) state_d = REQ;
        if (launch) begin
            addr_d = pc_eff;
            pc_d   = pc_eff + 32'd4;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pc_q     <= BOOT_ADDR;
            addr_q   <= BOOT_ADDR;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pq_rd_q  <= '0;
            pq_wr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples its pre-edge inputs.
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            if (branch_valid_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            if (granted) pq_wr_q <= pq_wr_q + ptr_t'(1);
            if (rsp)     pq_rd_q <= pq_rd_q + ptr_t'(1);
        end
    end

    // NOTE: storage arrays carry no reset; instr_valid_o gates every read, so stale words never escape.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= instr_rdata_i;
            pcf_mem[wr_ptr_q]  <= pq_mem[pq_rd_q];
        end
        if (granted) pq_mem[pq_wr_q] <= addr_q;
    end

    assign instr_req_o   = (state_q == REQ);
    assign instr_addr_o  = addr_q;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_data_o  = instr_valid_o ? data_mem[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? pcf_mem[rd_ptr_q]  : 32'h0;

endmodule
